// File: rtl/seq101_pkg.sv
// Shared "101" Moore detector definitions: state encoding and the single-bit
// next-state rule used by every detector instance in the codebase.
package seq101_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // S3 behaves like S0 for the incoming bit, so matches never overlap.
    function automatic state_t next_st(input state_t st, input logic b);
        state_t nxt;
        case (st)
            S0:      nxt = b ? S1 : S0;
            S1:      nxt = b ? S1 : S2;
            S2:      nxt = b ? S3 : S0;
            S3:      nxt = b ? S1 : S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping to 0. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq101_lane_scheduler.sv
// Time-shares one "101" detection engine across NUM_LANES serial lanes, each
// lane's 2-bit detector state being saved and restored around its grant.
module seq101_lane_scheduler
    import seq101_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = $clog2(NUM_LANES),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req,
    input  logic [NUM_LANES-1:0] bit_in,
    input  logic [NUM_LANES-1:0] clr,
    output logic [NUM_LANES-1:0] gnt,
    output logic [NUM_LANES-1:0] match,
    output logic                 det_valid,
    output logic [LANE_W-1:0]    det_lane,
    output logic [CNT_W-1:0]     det_count
);

    state_t              lane_st  [NUM_LANES];
    state_t              lane_nxt [NUM_LANES];
    logic [LANE_W-1:0]   ptr, ptr_nxt;
    logic [LANE_W-1:0]   gnt_idx;
    logic                any_gnt;
    state_t              eng_cur, eng_nxt;
    logic                enter_s3;
    logic                det_valid_nxt;
    logic [LANE_W-1:0]   det_lane_nxt;
    logic [CNT_W-1:0]    det_count_nxt;
    logic [NUM_LANES-1:0] eff;

    // A lane being cleared is never granted, so its bit stays with the source.
    assign eff = req & ~clr;

    rr_arbiter #(
        .N (NUM_LANES),
        .W (LANE_W)
    ) u_arb (
        .req (eff),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        any_gnt = |gnt;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (gnt[i]) gnt_idx = LANE_W'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) lane_st[i] <= S0;
            ptr       <= '0;
            det_valid <= 1'b0;
            det_lane  <= '0;
            det_count <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) lane_st[i] <= lane_nxt[i];
            ptr       <= ptr_nxt;
            det_valid <= det_valid_nxt;
            det_lane  <= det_lane_nxt;
            det_count <= det_count_nxt;
        end
    end

    always_comb begin
        eng_cur  = lane_st[gnt_idx];
        eng_nxt  = next_st(eng_cur, bit_in[gnt_idx]);
        enter_s3 = any_gnt && (eng_nxt == S3);

        for (int i = 0; i < NUM_LANES; i++) begin
            lane_nxt[i] = lane_st[i];
            if (clr[i])      lane_nxt[i] = S0;
            else if (gnt[i]) lane_nxt[i] = eng_nxt;
        end

        ptr_nxt = ptr;
        if (any_gnt) begin
            if (gnt_idx == LANE_W'(NUM_LANES - 1)) ptr_nxt = '0;
            else                                   ptr_nxt = gnt_idx + LANE_W'(1);
        end

        det_valid_nxt = enter_s3;
        det_lane_nxt  = enter_s3 ? gnt_idx : det_lane;
        det_count_nxt = det_count;
        if (enter_s3 && (det_count != '1)) det_count_nxt = det_count + CNT_W'(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) match[i] = (lane_st[i] == S3);
    end

endmodule

// File: tb/tb_seq101_lane_scheduler.sv
// Self-checking bench: directed scenarios plus held-request random traffic
// against a per-lane bit-history model of the "101" scheduler.
module tb_seq101_lane_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, bit_in, clr;
    logic [N-1:0] gnt, match, gnt_s, match_s;
    logic         det_valid, det_valid_s;
    logic [1:0]   det_lane, det_lane_s;
    logic [15:0]  det_count;
    logic [3:0]   det_count_s;

    int checks = 0;
    int errors = 0;

    // Model: ptr, per-lane history of bits since last detect/clear, outputs.
    int         m_ptr;
    int         m_len   [N];
    logic [2:0] m_hist  [N];
    bit         m_match [N];
    bit         m_dv;
    int         m_dl;
    int         m_cnt, m_cnt4;
    int         last_g;

    always #5 clk = ~clk;

    seq101_lane_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
        .gnt(gnt), .match(match), .det_valid(det_valid),
        .det_lane(det_lane), .det_count(det_count)
    );

    seq101_lane_scheduler #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .clr(clr),
        .gnt(gnt_s), .match(match_s), .det_valid(det_valid_s),
        .det_lane(det_lane_s), .det_count(det_count_s)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0; m_dv = 0; m_dl = 0; m_cnt = 0; m_cnt4 = 0;
        for (int i = 0; i < N; i++) begin
            m_len[i] = 0; m_hist[i] = '0; m_match[i] = 0;
        end
    endtask

    function automatic int modelGrant(input logic [N-1:0] r, input logic [N-1:0] c);
        for (int k = 0; k < N; k++) begin
            int l;
            l = (m_ptr + k) % N;
            if (r[l] && !c[l]) return l;
        end
        return -1;
    endfunction

    task automatic modelEdge(input int g, input logic [N-1:0] b, input logic [N-1:0] c);
        m_dv = 0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                m_len[i] = 0; m_hist[i] = '0; m_match[i] = 0;
            end
        end
        if (g >= 0) begin
            m_match[g] = 0;
            m_hist[g]  = {m_hist[g][1:0], b[g]};
            m_len[g]++;
            if (m_len[g] >= 3 && m_hist[g] == 3'b101) begin
                m_match[g] = 1; m_len[g] = 0; m_hist[g] = '0;
                m_dv = 1; m_dl = g;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic checkState();
        logic [N-1:0] em;
        for (int i = 0; i < N; i++) em[i] = m_match[i];
        checkOutput("match", match, em);
        checkOutput("match_sat", match_s, em);
        checkOutput("det_valid", det_valid, m_dv);
        checkOutput("det_valid_sat", det_valid_s, m_dv);
        checkOutput("det_lane", det_lane, m_dl[1:0]);
        checkOutput("det_count", det_count, m_cnt);
        checkOutput("det_count_sat", det_count_s, m_cnt4);
    endtask

    // One cycle: drive at negedge, check grant, advance model at posedge, check.
    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] b, input logic [N-1:0] c);
        logic [N-1:0] eg;
        @(negedge clk);
        req = r; bit_in = b; clr = c;
        #1;
        last_g = modelGrant(r, c);
        eg = (last_g < 0) ? '0 : (N'(1) << last_g);
        checkOutput("gnt", gnt, eg);
        checkOutput("gnt_sat", gnt_s, eg);
        @(posedge clk);
        modelEdge(last_g, b, c);
        #1;
        checkState();
    endtask

    task automatic doReset();
        @(negedge clk);
        req = '0; bit_in = '0; clr = '0;
        #2 reset = 1'b1;
        modelReset();
        #1;
        checkOutput("reset_gnt", gnt, 0);
        checkState();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [N-1:0] pend, pbit, rc;
    logic [2:0]   pat;

    initial begin
        reset = 1'b1; req = '0; bit_in = '0; clr = '0;
        modelReset();
        #12;
        checkState();
        checkOutput("reset_gnt", gnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Lane 0 alone: 1,0,1 then 0
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkOutput("tp1_match0", match[0], 1'b1);
        checkOutput("tp1_count", det_count, 1);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("tp1_drop", match[0], 1'b0);

        // All lanes requesting, each fed 1,0,1 over its own slots
        doReset();
        pat = 3'b101;
        for (int c = 0; c < 12; c++) applyStimulus(4'b1111, {N{pat[2 - c / 4]}}, 4'b0000);
        checkOutput("tp2_count", det_count, 4);

        // Lane 2 stream 1,0,1,0,1
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(4'b0100, (k % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000);
        checkOutput("tp3_count", det_count, 1);

        // Lane 1 in S2 then cleared while requesting
        doReset();
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        applyStimulus(4'b0010, 4'b0010, 4'b0010);
        applyStimulus(4'b0010, 4'b0010, 4'b0000);
        checkOutput("tp4_nodet", det_valid, 1'b0);

        // Reset between bits 2 and 3 of lane 0's pattern
        doReset();
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        doReset();
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        checkOutput("tp5_nodet", det_valid, 1'b0);
        applyStimulus(4'b1111, 4'b0000, 4'b0000);

        // Saturation on the narrow counter: 17 detections
        doReset();
        for (int k = 0; k < 51; k++) applyStimulus(4'b0001, (k % 3 == 1) ? 4'b0000 : 4'b0001, 4'b0000);
        checkOutput("tp6_sat", det_count_s, 15);
        checkOutput("tp6_wide", det_count, 17);

        // Random traffic; sources hold req/bit until granted
        doReset();
        pend = '0; pbit = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
                    pend[i] = 1'b1;
                    pbit[i] = ($urandom_range(0, 2) != 0);
                end
                rc[i] = ($urandom_range(0, 11) == 0);
            end
            applyStimulus(pend, pbit, rc);
            if (last_g >= 0) pend[last_g] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
